// File: rtl/bitty_pkg.sv
// Shared definitions for the operand bank: select codes, sizes, stage state.
// Select codes match the operand select mux encoding.
package bitty_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 10;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_REG0 = 4'h0;
  localparam sel_t SEL_REG1 = 4'h1;
  localparam sel_t SEL_REG2 = 4'h2;
  localparam sel_t SEL_REG3 = 4'h3;
  localparam sel_t SEL_REG4 = 4'h4;
  localparam sel_t SEL_REG5 = 4'h5;
  localparam sel_t SEL_REG6 = 4'h6;
  localparam sel_t SEL_REG7 = 4'h7;
  localparam sel_t SEL_IMM  = 4'h8;
  localparam sel_t SEL_DEF  = 4'h9;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } st_t;

  // Codes above SEL_DEF address nothing.
  function automatic logic sel_ok(sel_t s);
    return s <= SEL_DEF;
  endfunction

endpackage

// File: rtl/reg_write_bank_if.sv
// Write-back request channel into reg_write_bank.
// master: wr_valid/wr_sel/wr_data/hold out, wr_ready in; slave: reverse.
interface reg_write_bank_if
  import bitty_pkg::*;
#(
  parameter int DATA_W = 16
) ();

  logic              wr_valid;
  logic              wr_ready;
  sel_t              wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              hold;

  modport master (
    output wr_valid,
    output wr_sel,
    output wr_data,
    output hold,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_sel,
    input  wr_data,
    input  hold,
    output wr_ready
  );

endinterface

// File: rtl/reg_write_bank.sv
// Operand register bank: one-entry write stage feeding reg0-7/imm/def_val.
// Ports: clk, reset (sync, high), wr (slave: wr_valid/wr_ready/wr_sel/
// wr_data/hold), reg0..reg7, immediate, def_val, wr_err, commit_cnt.
// REG_BANK_BYPASS_EN: forward the staged entry to its output while FULL.
module reg_write_bank
  import bitty_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                CNT_W       = 8,
  parameter logic [DATA_W-1:0] DEF_VAL_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  reg_write_bank_if.slave   wr,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] immediate,
  output logic [DATA_W-1:0] def_val,
  output logic              wr_err,
  output logic [CNT_W-1:0]  commit_cnt
);

  st_t               st_q, st_d;
  sel_t              sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] out_w  [NREG];
  logic [NREG-1:0]   we;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fire;
  logic              commit;

  assign fire   = wr.wr_valid & wr.wr_ready;
  assign commit = (st_q == ST_FULL) & ~wr.hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_EMPTY;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_EMPTY: if (fire) st_d = ST_FULL;
      ST_FULL:  if (!wr.hold && !fire) st_d = ST_EMPTY;
      default:  st_d = ST_EMPTY;
    endcase
  end

  // Ready is a function of state and hold only, never wr_valid.
  always_comb begin
    wr.wr_ready = (st_q == ST_EMPTY) | ~wr.hold;
  end

  always_comb begin
    sel_d  = sel_q;
    data_d = data_q;
    if (fire) begin
      sel_d  = wr.wr_sel;
      data_d = wr.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      sel_q  <= sel_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    we = '0;
    for (int i = 0; i < NREG; i++) begin
      we[i] = commit & (sel_q == sel_t'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset) begin
        regs_q[i] <= (sel_t'(i) == SEL_DEF) ? DEF_VAL_RST : '0;
      end else if (we[i]) begin
        regs_q[i] <= data_q;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (commit) begin
      if (sel_ok(sel_q)) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      out_w[i] = regs_q[i];
`ifdef REG_BANK_BYPASS_EN
      // Invalid codes match no slot, so they forward nothing.
      if (st_q == ST_FULL && sel_q == sel_t'(i)) begin
        out_w[i] = data_q;
      end
`endif
    end
  end

  assign reg0       = out_w[SEL_REG0];
  assign reg1       = out_w[SEL_REG1];
  assign reg2       = out_w[SEL_REG2];
  assign reg3       = out_w[SEL_REG3];
  assign reg4       = out_w[SEL_REG4];
  assign reg5       = out_w[SEL_REG5];
  assign reg6       = out_w[SEL_REG6];
  assign reg7       = out_w[SEL_REG7];
  assign immediate  = out_w[SEL_IMM];
  assign def_val    = out_w[SEL_DEF];
  assign wr_err     = err_q;
  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_bank.sv
// Randomized + directed bench for reg_write_bank against a queue-style model.
// Honors REG_BANK_BYPASS_EN for the expected output view.
module tb_reg_write_bank;
  import bitty_pkg::*;

  localparam int W  = 16;
  localparam int CW = 8;
  localparam logic [W-1:0] DEFV = 16'hBEEF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] dout [10];
  logic         wr_err;
  logic [CW-1:0] commit_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] m_reg [10];
  int           m_cnt;
  bit           m_err;
  bit           m_full;
  int           m_sel;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  reg_write_bank_if #(.DATA_W(W)) bus ();

  reg_write_bank #(
    .DATA_W(W), .CNT_W(CW), .DEF_VAL_RST(DEFV)
  ) dut (
    .clk(clk), .reset(reset), .wr(bus.slave),
    .reg0(dout[0]), .reg1(dout[1]), .reg2(dout[2]),
    .reg3(dout[3]), .reg4(dout[4]), .reg5(dout[5]),
    .reg6(dout[6]), .reg7(dout[7]),
    .immediate(dout[8]), .def_val(dout[9]),
    .wr_err(wr_err), .commit_cnt(commit_cnt)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_outs();
    logic [W-1:0] e;
    for (int i = 0; i < 10; i++) begin
      e = m_reg[i];
`ifdef REG_BANK_BYPASS_EN
      if (m_full && m_sel == i) e = m_data;
`endif
      chk($sformatf("reg%0d", i), dout[i], e);
    end
    chk("wr_err", wr_err, m_err);
    chk("cnt", commit_cnt, m_cnt);
  endtask

  // One clock: drive at negedge, check ready, step model at posedge.
  task automatic cyc(input bit rst, input bit v, input int s,
                     input logic [W-1:0] d, input bit h,
                     output bit acc);
    bit rdy, commit;
    @(negedge clk);
    reset        = rst;
    bus.wr_valid = v;
    bus.wr_sel   = s[3:0];
    bus.wr_data  = d;
    bus.hold     = h;
    #1;
    rdy = !m_full || !h;
    chk("wr_ready", bus.wr_ready, rdy);
    @(posedge clk);
    #1;
    acc = 0;
    if (rst) begin
      for (int i = 0; i < 10; i++) m_reg[i] = '0;
      m_reg[9] = DEFV;
      m_cnt = 0; m_err = 0; m_full = 0;
    end else begin
      commit = m_full && !h;
      m_err = commit && m_sel > 9;
      if (commit && m_sel <= 9) begin
        m_reg[m_sel] = m_data;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      acc = v && rdy;
      if (acc) begin
        m_full = 1; m_sel = s; m_data = d;
      end else if (commit) begin
        m_full = 0;
      end
    end
    check_outs();
  endtask

  initial begin
    bit a;
    int s;
    bit v;
    logic [W-1:0] d;
    bus.wr_valid = 0; bus.wr_sel = 0; bus.wr_data = 0; bus.hold = 0;

    cyc(1, 0, 0, 0, 0, a);
    chk("rst_def", dout[9], DEFV);
    // 1: simple write
    cyc(0, 1, 3, 16'hABCD, 0, a);
    cyc(0, 0, 0, 0, 0, a);
    chk("t1_reg3", dout[3], 16'hABCD);
    chk("t1_cnt", commit_cnt, 1);
    // 2: hold stalls commit
    cyc(0, 1, 1, 16'h1111, 1, a);
    cyc(0, 0, 0, 0, 1, a);
    chk("t2_rdy", bus.wr_ready, 0);
    chk("t2_reg1", dout[1], 0);
    cyc(0, 0, 0, 0, 0, a);
    chk("t2_reg1b", dout[1], 16'h1111);
    // 3: streaming, one accept per cycle
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, i, 16'h0100 + 16'(i), 0, a);
      chk("t3_acc", a, 1);
    end
    cyc(0, 0, 0, 0, 0, a);
    chk("t3_cnt", commit_cnt, 12);
    chk("t3_imm", dout[8], 16'h0108);
    // 4: invalid select
    cyc(0, 1, 12, 16'hFFFF, 0, a);
    cyc(0, 0, 0, 0, 0, a);
    chk("t4_err", wr_err, 1);
    cyc(0, 0, 0, 0, 0, a);
    chk("t4_err_off", wr_err, 0);
    chk("t4_cnt", commit_cnt, 12);
    // 5: reset while FULL
    cyc(0, 1, 8, 16'h1234, 1, a);
    cyc(1, 0, 0, 0, 1, a);
    chk("t5_imm", dout[8], 0);
    cyc(0, 0, 0, 0, 1, a);
    chk("t5_rdy", bus.wr_ready, 1);
    // 6: staged view under hold
    cyc(0, 1, 5, 16'h5A5A, 1, a);
    cyc(0, 0, 0, 0, 1, a);
`ifdef REG_BANK_BYPASS_EN
    chk("t6_reg5", dout[5], 16'h5A5A);
`else
    chk("t6_reg5", dout[5], 16'h0000);
`endif
    cyc(0, 0, 0, 0, 0, a);
    chk("t6_reg5c", dout[5], 16'h5A5A);

    // Random: sender keeps request stable until accepted.
    v = 0; s = 0; d = 0; a = 1;
    for (int n = 0; n < 600; n++) begin
      if (a || !v) begin
        v = ($urandom_range(0, 3) != 0);
        s = $urandom_range(0, 15);
        d = W'($urandom);
      end
      cyc($urandom_range(0, 63) == 0, v, s, d,
          $urandom_range(0, 2) == 0, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
